alu_mc: RTL and testbench

//  Parametrised, handshaked execute unit for MinCPU; next generation of the single-cycle ALU.
//  - Adds registered outputs, valid/ready flow control, a synchronous flush,
//    and an iterative radix-2 unsigned multiplier (MUL, MULHU).
//  - Sits between ID/EX operand latch and the EX/MEM stage.
//  - Fast ops retire in 1 cycle; multiplies hold the unit for DATA_WIDTH cycles.

---
 rtl/alu_mc.sv | 148 ++++++++++++++
 tb/tb_alu_mc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Handshaked execute unit: single-cycle fast ops plus an iterative radix-2
// unsigned multiplier (MUL/MULHU) behind a registered, backpressured result.
module alu_mc #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [3:0]            alu_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  illegal
);
  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [2*W-1:0]       r_acc;
  logic [W-1:0]         r_mcand, r_mplier;
  logic                 r_hi_sel;
  logic [SHAMT_W-1:0]   r_count;
  logic                 r_out_valid, r_zero, r_illegal;
  logic [W-1:0]         r_result;

  logic                 w_drain, w_accept, w_is_mul, w_last;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [W:0]           w_sum;
  logic [2*W-1:0]       w_acc_nxt, w_prod;
  logic [W-1:0]         w_mul_res, w_fast, w_load_res;
  logic                 w_fast_ill, w_load, w_load_ill;

  assign w_drain  = ~r_out_valid | out_ready;
  assign in_ready = (r_state == S_IDLE) & w_drain & ~flush;
  assign w_accept = in_valid & in_ready;
  assign w_is_mul = (alu_op[3:1] == 3'b110);
  assign w_last   = (r_count == SHAMT_W'(W-1));
  assign w_shamt  = src2[SHAMT_W-1:0];

  // Add into the upper half with carry, then shift the whole accumulator right.
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_mcand};
  assign w_acc_nxt = r_mplier[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};
  assign w_prod    = (r_state == S_MUL) ? w_acc_nxt : r_acc;
  assign w_mul_res = r_hi_sel ? w_prod[2*W-1:W] : w_prod[W-1:0];

  always_comb begin
    w_fast     = '0;
    w_fast_ill = 1'b0;
    case (alu_op)
      4'h0: w_fast = src1 + src2;
      4'h1: w_fast = src1 - src2;
      4'h2: w_fast = src1 & src2;
      4'h3: w_fast = src1 | src2;
      4'h4: w_fast = src1 ^ src2;
      4'h5: w_fast = src1 << w_shamt;
      4'h6: w_fast = src1 >> w_shamt;
      4'h7: w_fast = $unsigned($signed(src1) >>> w_shamt);
      4'h8: w_fast = {{(W-1){1'b0}}, ($signed(src1) < $signed(src2))};
      4'h9: w_fast = {{(W-1){1'b0}}, (src1 < src2)};
      4'hA: w_fast = src1;
      4'hB: w_fast = src2;
      4'hE, 4'hF: w_fast_ill = 1'b1;
      default: w_fast = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:  if (w_last) w_state_nxt = w_drain ? S_IDLE : S_WAIT;
      S_WAIT: if (w_drain) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_load     = 1'b0;
    w_load_res = w_mul_res;
    w_load_ill = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load     = w_accept & ~w_is_mul;
        w_load_res = w_fast;
        w_load_ill = w_fast_ill;
      end
      S_MUL:  w_load = w_last & w_drain;
      S_WAIT: w_load = w_drain;
      default: w_load = 1'b0;
    endcase
    if (flush) w_load = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_hi_sel    <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_load_res;
        r_zero      <= (w_load_res == '0);
        r_illegal   <= w_load_ill;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_state == S_IDLE && w_accept && w_is_mul) begin
        r_acc    <= '0;
        r_mcand  <= src1;
        r_mplier <= src2;
        r_hi_sel <= alu_op[0];
        r_count  <= '0;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes hand-computed results, a
// negedge monitor pops and compares whenever a result retires.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] src1, src2, result;
  logic [3:0]  alu_op;
  logic        zero, illegal;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        il;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   tag   = 0;

  alu_mc #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got=%h (nothing expected)", result);
      end else begin
        e = sb.pop_front();
        if (result !== e.r || zero !== e.z || illegal !== e.il) begin
          bad++;
          $display("FAIL result_op%0d got=%h z=%b il=%b exp=%h z=%b il=%b",
                   e.id, result, zero, illegal, e.r, e.z, e.il);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z, input logic il, input bit push);
    int n = 0;
    alu_op = op; src1 = a; src2 = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    if (push) begin
      sb.push_back('{r: r, z: z, il: il, id: tag});
    end
    tag++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid appears.
  task automatic mul_latency(input string nm);
    int  n = 0;
    bit  busy_ok = 1'b1;
    forever begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid || n > 60) break;
      if (in_ready) busy_ok = 1'b0;
    end
    chk({nm, "_latency"}, n, 32);
    chk({nm, "_in_ready_low"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; alu_op = '0;
    @(posedge clk); #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {30'd0, zero, illegal}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fast op latency and back-to-back throughput
    issue(4'h0, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 1'b1);
    chk("add_valid_after_edge", {31'd0, out_valid}, 32'd1);
    chk("add_result_after_edge", result, 32'd12);
    issue(4'h1, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b1);
    issue(4'h7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
    issue(4'h2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b1);
    issue(4'h3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1);
    issue(4'h4, 32'hFF, 32'hFF, 32'h0, 1'b1, 1'b0, 1'b1);
    issue(4'h5, 32'd1, 32'd33, 32'd2, 1'b0, 1'b0, 1'b1);
    issue(4'h6, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(4'h8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(4'h9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1);
    issue(4'hA, 32'hDEAD_BEEF, 32'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    issue(4'hB, 32'hDEAD_BEEF, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1);
    issue(4'hF, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 1'b1);
    issue(4'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1);

    // Multiplies
    issue(4'hC, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    mul_latency("mul");
    issue(4'hD, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    mul_latency("mulhu");
    issue(4'hD, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    mul_latency("mulhu_big");
    issue(4'hC, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b1);
    mul_latency("mul_big");

    // Backpressure on multiply completion: result holds, nothing accepted
    out_ready = 1'b0;
    issue(4'hC, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    alu_op = 4'h0; src1 = 32'd9; src2 = 32'd9; in_valid = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!out_valid || result !== 32'd15 || in_ready) quiet = 1'b0;
    end
    chk("bp_hold_stable", {31'd0, quiet}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    issue(4'h0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b1);

    // Flush during iteration 10
    issue(4'hC, 32'h1234, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    chk("flush_no_result", {31'd0, quiet}, 32'd1);
    @(posedge clk); #1;
    issue(4'h0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);

    // Async reset mid-multiply, then a reserved op
    issue(4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'd0, zero, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(4'hE, 32'd5, 32'd6, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("illegal_after_edge", {31'd0, illegal}, 32'd1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
